// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: control word, memop encoding, FSM state codes
// and the byte-enable / alignment helpers.
package mem_stage_pkg;

    localparam int RVGA_XLEN = 32;

    typedef enum logic [2:0] {
        MEM_LB,
        MEM_LH,
        MEM_LW,
        MEM_LBU,
        MEM_LHU,
        MEM_SB,
        MEM_SH,
        MEM_SW
    } rvga_memop;

    typedef struct packed {
        logic [RVGA_XLEN-1:0] pc;
        logic [4:0]           rd_addr;
        logic                 rd_wen;
        logic                 mem_read;
        logic                 mem_write;
        rvga_memop            memop;
        logic [RVGA_XLEN-1:0] rd_data;   // ALU result / effective address
        logic [RVGA_XLEN-1:0] rs2_data;  // store data
    } rvga_cword;

    typedef logic [1:0] mem_state;

    localparam mem_state ST_IDLE = 2'd0;
    localparam mem_state ST_WAIT = 2'd1;
    localparam mem_state ST_DONE = 2'd2;

    // Halfword lanes use addr[1] only and words ignore the low bits entirely.
    function automatic logic [3:0] byte_en(rvga_memop op, logic [1:0] a);
        logic [3:0] be;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << a;
            MEM_LH, MEM_LHU, MEM_SH: be = 4'b0011 << {a[1], 1'b0};
            default:                 be = 4'hF;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(rvga_memop op, logic [1:0] a);
        logic m;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: m = a[0];
            MEM_LW, MEM_SW:          m = |a;
            default:                 m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: picks the addressed byte/halfword/word out of the read data and
// sign- or zero-extends it according to the load type.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = RVGA_XLEN
) (
    input  logic [XLEN-1:0] rdata_i,
    input  rvga_memop       memop_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign lane_h = addr_lo_i[1] ? rdata_i[16 +: 16] : rdata_i[0 +: 16];

    always_comb begin
        data_o = '0;
        case (memop_i)
            MEM_LB:  data_o = {{(XLEN-8){lane_b[7]}}, lane_b};
            MEM_LBU: data_o = {{(XLEN-8){1'b0}}, lane_b};
            MEM_LH:  data_o = {{(XLEN-16){lane_h[15]}}, lane_h};
            MEM_LHU: data_o = {{(XLEN-16){1'b0}}, lane_h};
            MEM_LW:  data_o = rdata_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores on the dmem req/ack port and merges load
// data into the writeback control word. Optional feature: RVGA_MISALIGN_TRAP_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN        = RVGA_XLEN,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    input  rvga_cword       ex_mem_cword,
    output rvga_cword       mem_wb_cword,
    output logic            stall_out,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_err,
    output logic            misalign_err
);

    localparam int             CW  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0]  TMO = CW'(ACK_TIMEOUT);

    mem_state        state_q, state_d;
    rvga_cword       cw_q, cw_d;
    rvga_cword       wb_q, wb_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            err_q, err_d;

    logic            is_mem;
    logic            mis;
    logic            mis_evt;
    logic [XLEN-1:0] st_data;
    logic [XLEN-1:0] ld_data;

    assign is_mem  = ex_mem_cword.mem_read | ex_mem_cword.mem_write;
    assign cnt_inc = cnt_q + CW'(1);

`ifdef RVGA_MISALIGN_TRAP_EN
    assign mis = misaligned(ex_mem_cword.memop, ex_mem_cword.rd_data[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign mis_evt = (state_q == ST_IDLE) && is_mem && mis;

    // Store data is replicated across every lane so the byte enables alone pick the target.
    always_comb begin
        st_data = ex_mem_cword.rs2_data;
        case (ex_mem_cword.memop)
            MEM_SB:  st_data = {(XLEN/8){ex_mem_cword.rs2_data[7:0]}};
            MEM_SH:  st_data = {(XLEN/16){ex_mem_cword.rs2_data[15:0]}};
            default: st_data = ex_mem_cword.rs2_data;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i   (dmem_rdata),
        .memop_i   (cw_q.memop),
        .addr_lo_i (cw_q.rd_data[1:0]),
        .data_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        wb_d    = wb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    // Execute is frozen by stall_out, but it moves on in DONE, so keep a copy.
                    cw_d  = ex_mem_cword;
                    cnt_d = '0;
                    if (mis_evt) begin
                        res_d       = '0;
                        cw_d.rd_wen = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = ex_mem_cword.mem_write;
                        addr_d  = {ex_mem_cword.rd_data[XLEN-1:2], 2'b00};
                        wdata_d = st_data;
                        be_d    = byte_en(ex_mem_cword.memop, ex_mem_cword.rd_data[1:0]);
                        state_d = ST_WAIT;
                    end
                end else if (!stall_in) begin
                    wb_d = ex_mem_cword;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    res_d   = ld_data;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_inc == TMO) begin
                    res_d   = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (!stall_in) begin
                    wb_d = cw_q;
                    if (cw_q.mem_read) wb_d.rd_data = res_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cw_q    <= '0;
            wb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            wb_q    <= wb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

`ifdef RVGA_MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge clk) begin
        if (!rst_n) mis_q <= 1'b0;
        else        mis_q <= mis_evt;
    end
    assign misalign_err = mis_q;
`else
    assign misalign_err = 1'b0;
`endif

    assign stall_out    = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && is_mem);
    assign mem_wb_cword = wb_q;
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign dmem_err     = err_q;

endmodule
